// File: rtl/cci_mpf_shim_req_throttle.sv
// Request throttle between the AFU-side request buffer and the FIU.
// Dequeues buffered read/write heads when the FIU has room, the channel
// has outstanding-request credit and no drain is requested, then forwards
// each accepted request through one register stage. Completions return
// credits; a completion with no outstanding request raises a sticky error.
module cci_mpf_shim_req_throttle #(
  parameter int C0_HDR_BITS = 74,
  parameter int C1_REQ_BITS = 592,
  parameter int MAX_READS   = 128,
  parameter int MAX_WRITES  = 128,
  localparam int RD_W = $clog2(MAX_READS + 1),
  localparam int WR_W = $clog2(MAX_WRITES + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   buf_c0_valid,
  input  logic [C0_HDR_BITS-1:0] buf_c0_hdr,
  output logic                   deq_c0,
  input  logic                   buf_c1_valid,
  input  logic [C1_REQ_BITS-1:0] buf_c1_req,
  output logic                   deq_c1,
  input  logic                   fiu_c0_alm_full,
  input  logic                   fiu_c1_alm_full,
  output logic                   fiu_c0_valid,
  output logic [C0_HDR_BITS-1:0] fiu_c0_hdr,
  output logic                   fiu_c1_valid,
  output logic [C1_REQ_BITS-1:0] fiu_c1_req,
  input  logic                   rsp_c0_read,
  input  logic                   rsp_c1_write,
  input  logic                   drain,
  output logic [RD_W-1:0]        rd_outstanding,
  output logic [WR_W-1:0]        wr_outstanding,
  output logic                   idle,
  output logic                   credit_err
);

  localparam logic [RD_W-1:0] RD_MAX = RD_W'(MAX_READS);
  localparam logic [WR_W-1:0] WR_MAX = WR_W'(MAX_WRITES);

  logic [RD_W-1:0] rd_cnt, rd_cnt_next;
  logic [WR_W-1:0] wr_cnt, wr_cnt_next;
  logic            rd_underflow, wr_underflow;

  // Issue decision: each channel independent, limit checked on the
  // registered count so a same-cycle response frees credit only next cycle.
  always_comb begin
    deq_c0 = reset_n & buf_c0_valid & ~fiu_c0_alm_full & ~drain & (rd_cnt < RD_MAX);
    deq_c1 = reset_n & buf_c1_valid & ~fiu_c1_alm_full & ~drain & (wr_cnt < WR_MAX);
  end

  // Credit counter next-state; a response against an empty counter holds
  // the count at zero and flags an underflow instead of wrapping.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    rd_cnt_next  = rd_cnt;
    rd_underflow = 1'b0;
    if (deq_c0 && !rsp_c0_read) begin
      rd_cnt_next = rd_cnt + RD_W'(1);
    end else if (!deq_c0 && rsp_c0_read) begin
      if (rd_cnt == '0) rd_underflow = 1'b1;
      else              rd_cnt_next  = rd_cnt - RD_W'(1);
    end

    wr_cnt_next  = wr_cnt;
    wr_underflow = 1'b0;
    if (deq_c1 && !rsp_c1_write) begin
      wr_cnt_next = wr_cnt + WR_W'(1);
    end else if (!deq_c1 && rsp_c1_write) begin
      if (wr_cnt == '0) wr_underflow = 1'b1;
      else              wr_cnt_next  = wr_cnt - WR_W'(1);
    end
  end

  // State register: forwarding stage, credit counters and sticky error.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      // NOTE: the payload registers are cleared too, so the outputs read
      // as zero after reset rather than holding stale request contents.
      fiu_c0_valid <= 1'b0;
      fiu_c0_hdr   <= '0;
      fiu_c1_valid <= 1'b0;
      fiu_c1_req   <= '0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      credit_err   <= 1'b0;
    end else begin
      fiu_c0_valid <= deq_c0;
      fiu_c1_valid <= deq_c1;
      if (deq_c0) fiu_c0_hdr <= buf_c0_hdr;
      if (deq_c1) fiu_c1_req <= buf_c1_req;
      rd_cnt       <= rd_cnt_next;
      wr_cnt       <= wr_cnt_next;
      credit_err   <= credit_err | rd_underflow | wr_underflow;
    end
  end

  // Status outputs derived from registered state only.
  always_comb begin
    rd_outstanding = rd_cnt;
    wr_outstanding = wr_cnt;
    idle = (rd_cnt == '0) & (wr_cnt == '0) & ~fiu_c0_valid & ~fiu_c1_valid;
  end

endmodule

// File: tb/tb_cci_mpf_shim_req_throttle.sv
// Directed bench for the request throttle with MAX_READS = MAX_WRITES = 4.
// Inputs change 1 time unit after the rising edge; combinational dequeue
// outputs are checked 1 unit later, registered outputs 1 unit after the
// following rising edge.
module tb_cci_mpf_shim_req_throttle;

  localparam int HB = 16;
  localparam int RB = 24;
  localparam int MR = 4;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          buf_c0_valid;
  logic [HB-1:0] buf_c0_hdr;
  logic          deq_c0;
  logic          buf_c1_valid;
  logic [RB-1:0] buf_c1_req;
  logic          deq_c1;
  logic          fiu_c0_alm_full;
  logic          fiu_c1_alm_full;
  logic          fiu_c0_valid;
  logic [HB-1:0] fiu_c0_hdr;
  logic          fiu_c1_valid;
  logic [RB-1:0] fiu_c1_req;
  logic          rsp_c0_read;
  logic          rsp_c1_write;
  logic          drain;
  logic [2:0]    rd_outstanding;
  logic [2:0]    wr_outstanding;
  logic          idle;
  logic          credit_err;

  cci_mpf_shim_req_throttle #(
    .C0_HDR_BITS(HB), .C1_REQ_BITS(RB), .MAX_READS(MR), .MAX_WRITES(MW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .buf_c0_valid(buf_c0_valid), .buf_c0_hdr(buf_c0_hdr), .deq_c0(deq_c0),
    .buf_c1_valid(buf_c1_valid), .buf_c1_req(buf_c1_req), .deq_c1(deq_c1),
    .fiu_c0_alm_full(fiu_c0_alm_full), .fiu_c1_alm_full(fiu_c1_alm_full),
    .fiu_c0_valid(fiu_c0_valid), .fiu_c0_hdr(fiu_c0_hdr),
    .fiu_c1_valid(fiu_c1_valid), .fiu_c1_req(fiu_c1_req),
    .rsp_c0_read(rsp_c0_read), .rsp_c1_write(rsp_c1_write), .drain(drain),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .idle(idle), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          c0v;
    logic [HB-1:0] hdr;
    logic          c1v;
    logic [RB-1:0] req;
    logic          a0, a1, r0, r1, dr;
    logic          e_deq0, e_deq1;
    int            e_rd, e_wr;
    logic          e_idle, e_err;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t v(input logic c0v, input logic [HB-1:0] hdr,
                             input logic c1v, input logic [RB-1:0] req,
                             input logic a0, input logic a1, input logic r0,
                             input logic r1, input logic dr,
                             input logic e_deq0, input logic e_deq1,
                             input int e_rd, input int e_wr,
                             input logic e_idle, input logic e_err);
    vec_t t;
    t.c0v = c0v; t.hdr = hdr; t.c1v = c1v; t.req = req;
    t.a0 = a0; t.a1 = a1; t.r0 = r0; t.r1 = r1; t.dr = dr;
    t.e_deq0 = e_deq0; t.e_deq1 = e_deq1; t.e_rd = e_rd; t.e_wr = e_wr;
    t.e_idle = e_idle; t.e_err = e_err;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    buf_c0_valid    = t.c0v;
    buf_c0_hdr      = t.hdr;
    buf_c1_valid    = t.c1v;
    buf_c1_req      = t.req;
    fiu_c0_alm_full = t.a0;
    fiu_c1_alm_full = t.a1;
    rsp_c0_read     = t.r0;
    rsp_c1_write    = t.r1;
    drain           = t.dr;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Apply one vector: check dequeues in-cycle, then registered state.
  task automatic apply(input int idx, input vec_t t);
    string tag;
    tag = $sformatf("v%0d", idx);
    drive(t);
    #1;
    check({tag, ".deq_c0"}, 32'(deq_c0), 32'(t.e_deq0));
    check({tag, ".deq_c1"}, 32'(deq_c1), 32'(t.e_deq1));
    next_edge();
    check({tag, ".fiu_c0_valid"}, 32'(fiu_c0_valid), 32'(t.e_deq0));
    check({tag, ".fiu_c1_valid"}, 32'(fiu_c1_valid), 32'(t.e_deq1));
    if (t.e_deq0) check({tag, ".fiu_c0_hdr"}, 32'(fiu_c0_hdr), 32'(t.hdr));
    if (t.e_deq1) check({tag, ".fiu_c1_req"}, 32'(fiu_c1_req), 32'(t.req));
    check({tag, ".rd_outstanding"}, 32'(rd_outstanding), 32'(t.e_rd));
    check({tag, ".wr_outstanding"}, 32'(wr_outstanding), 32'(t.e_wr));
    check({tag, ".idle"}, 32'(idle), 32'(t.e_idle));
    check({tag, ".credit_err"}, 32'(credit_err), 32'(t.e_err));
  endtask

  initial begin
    //           c0v hdr       c1v req        a0 a1 r0 r1 dr  d0 d1 rd wr idle err
    // credit limit on reads, response at the limit, issue+response together
    vecs.push_back(v(1, 16'h00A1, 0, 24'h0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(v(1, 16'h00A2, 0, 24'h0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0));
    vecs.push_back(v(1, 16'h00A3, 0, 24'h0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0));
    vecs.push_back(v(1, 16'h00A4, 0, 24'h0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0));
    vecs.push_back(v(1, 16'h00A5, 0, 24'h0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0));
    vecs.push_back(v(1, 16'h00A5, 0, 24'h0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(v(1, 16'h00A5, 0, 24'h0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0));
    vecs.push_back(v(1, 16'h00A6, 0, 24'h0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(v(1, 16'h00A6, 0, 24'h0, 0, 0, 1, 0, 0, 1, 0, 3, 0, 0, 0));
    // write almost-full for three cycles, then release
    vecs.push_back(v(0, 16'h0000, 1, 24'hB00001, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(v(0, 16'h0000, 1, 24'hB00001, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(v(0, 16'h0000, 1, 24'hB00001, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(v(0, 16'h0000, 1, 24'hB00001, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0));
    // drain with 2 reads + 1 write outstanding
    vecs.push_back(v(0, 16'h0000, 0, 24'h0, 0, 0, 1, 0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(v(1, 16'h00A7, 1, 24'hB00002, 0, 0, 0, 0, 1, 0, 0, 2, 1, 0, 0));
    vecs.push_back(v(1, 16'h00A7, 1, 24'hB00002, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(v(1, 16'h00A7, 1, 24'hB00002, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(1, 16'h00A7, 1, 24'hB00002, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0));
    // credit error: sticky across later traffic
    vecs.push_back(v(0, 16'h0000, 0, 24'h0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 16'h0000, 0, 24'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(v(1, 16'h00A8, 0, 24'h0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
    vecs.push_back(v(0, 16'h0000, 0, 24'h0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1));
    // read almost-full blocks issue
    vecs.push_back(v(1, 16'h00A9, 0, 24'h0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));

    // Reset with a read waiting: dequeue must stay low during reset.
    reset_n = 1'b0;
    drive(v(1, 16'h0055, 1, 24'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("rst.deq_c0", 32'(deq_c0), 32'd0);
    check("rst.deq_c1", 32'(deq_c1), 32'd0);
    next_edge();
    next_edge();
    check("rst.rd_outstanding", 32'(rd_outstanding), 32'd0);
    check("rst.wr_outstanding", 32'(wr_outstanding), 32'd0);
    check("rst.fiu_c0_valid", 32'(fiu_c0_valid), 32'd0);
    check("rst.fiu_c1_valid", 32'(fiu_c1_valid), 32'd0);
    check("rst.idle", 32'(idle), 32'd1);
    check("rst.credit_err", 32'(credit_err), 32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) apply(i, vecs[i]);

    // Reset mid-traffic: bring reads to 3 with a request in flight.
    apply(100, v(1, 16'h00C1, 0, 24'h0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1));
    apply(101, v(1, 16'h00C2, 0, 24'h0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 1));
    reset_n = 1'b0;
    drive(v(1, 16'h00C3, 0, 24'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("mid_rst.deq_c0", 32'(deq_c0), 32'd0);
    next_edge();
    check("mid_rst.rd_outstanding", 32'(rd_outstanding), 32'd0);
    check("mid_rst.fiu_c0_valid", 32'(fiu_c0_valid), 32'd0);
    check("mid_rst.fiu_c0_hdr", 32'(fiu_c0_hdr), 32'd0);
    check("mid_rst.credit_err", 32'(credit_err), 32'd0);
    check("mid_rst.idle", 32'(idle), 32'd1);
    reset_n = 1'b1;
    apply(102, v(1, 16'h00C3, 0, 24'h0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));

    // Write credit limit: four writes issue, the fifth is held.
    for (int i = 0; i < 5; i++) begin
      apply(200 + i, v(0, 16'h0000, 1, 24'hD00000 + 24'(i), 0, 0, 0, 0, 0,
                       (i < 4) ? 1'b0 : 1'b0, (i < 4) ? 1'b1 : 1'b0,
                       1, (i < 4) ? i + 1 : 4, 0, 0));
    end
    // Write ack at the limit frees credit only for the following cycle.
    apply(210, v(0, 16'h0000, 1, 24'hD00004, 0, 0, 0, 1, 0, 0, 0, 1, 3, 0, 0));
    apply(211, v(0, 16'h0000, 1, 24'hD00004, 0, 0, 0, 0, 0, 0, 1, 1, 4, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cci_mpf_shim_req_throttle.md
Name: cci_mpf_shim_req_throttle

Overview:
- Sits directly downstream of the AFU-side request buffer shim.
- Consumes the buffered channel 0 (read) and channel 1 (write) request heads and generates the buffer's dequeue strobes.
- Forwards each accepted request through one register stage toward the FIU, gated by FIU almost-full and by per-channel outstanding-request credit limits.
- Counts completions to return credits, and supports a drain/quiesce control for fence and reset sequencing.

Parameters:
- C0_HDR_BITS, default CCI_MPF_TX_MEMHDR_WIDTH: width of a channel 0 request header.
- C1_REQ_BITS, default $bits(t_if_cci_mpf_c1_Tx): width of a full channel 1 request (header plus data, valids excluded).
- MAX_READS, default 128: maximum outstanding reads, range 1..1023.
- MAX_WRITES, default 128: maximum outstanding writes, range 1..1023.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- buf_c0_valid  in  1  buffered channel 0 head is valid
- buf_c0_hdr  in  C0_HDR_BITS  buffered channel 0 head header
- deq_c0  out  1  dequeue buffered channel 0 head (combinational)
- buf_c1_valid  in  1  buffered channel 1 head is valid
- buf_c1_req  in  C1_REQ_BITS  buffered channel 1 head
- deq_c1  out  1  dequeue buffered channel 1 head (combinational)
- fiu_c0_alm_full  in  1  FIU channel 0 almost full
- fiu_c1_alm_full  in  1  FIU channel 1 almost full
- fiu_c0_valid  out  1  registered read request valid
- fiu_c0_hdr  out  C0_HDR_BITS  registered read header
- fiu_c1_valid  out  1  registered write request valid
- fiu_c1_req  out  C1_REQ_BITS  registered write request
- rsp_c0_read  in  1  one read response received (returns one read credit)
- rsp_c1_write  in  1  one write ack received (returns one write credit)
- drain  in  1  stop issuing new requests while asserted
- rd_outstanding  out  $clog2(MAX_READS+1)  current outstanding read count
- wr_outstanding  out  $clog2(MAX_WRITES+1)  current outstanding write count
- idle  out  1  nothing in flight
- credit_err  out  1  sticky: a response arrived with its counter at zero

Behaviour:
- Reset (reset_n==0 at a clk edge): all registered outputs, both counters and credit_err clear to 0. deq_c0 and deq_c1 are forced to 0 while reset_n is low. Reset mid-operation discards any in-flight count without error.
- Issue conditions (combinational):
  - deq_c0 = buf_c0_valid & !fiu_c0_alm_full & !drain & (rd_cnt < MAX_READS).
  - deq_c1 = buf_c1_valid & !fiu_c1_alm_full & !drain & (wr_cnt < MAX_WRITES).
  - The two channels are fully independent; there is no arbitration between them.
- Forwarding latency is exactly 1 cycle:
  - fiu_c0_valid <= deq_c0; fiu_c0_hdr <= buf_c0_hdr when deq_c0 (header held otherwise).
  - Channel 1 follows the same rule with fiu_c1_valid, fiu_c1_req and deq_c1.
  - Valid is never held high for more than one cycle per dequeue.
- Counter update each cycle:
  - rd_cnt next = rd_cnt + deq_c0 - rsp_c0_read.
  - Issue and response in the same cycle leave the count unchanged, even when rd_cnt==MAX_READS.
  - Issue is blocked at MAX_READS in any cycle without a response. A response in that cycle does not unblock issue combinationally; the freed credit is usable the following cycle.
  - Response with rd_cnt==0 and no issue in the same cycle: rd_cnt stays 0 and credit_err sets. credit_err clears only on reset.
  - The write channel follows the same rules using wr_cnt, deq_c1, rsp_c1_write and MAX_WRITES.
- Counters are saturating-safe; neither wraps.
- idle = (rd_cnt==0) & (wr_cnt==0) & !fiu_c0_valid & !fiu_c1_valid. idle is independent of buffer contents.
- Almost-full gating uses the current-cycle value. The FIU almost-full slack absorbs the one registered request already in flight.
- drain:
  - Assertion blocks dequeues in the same cycle.
  - Responses continue to return credits during drain.
  - Deasserting drain resumes issue the same cycle.

Test Plan:
- Credit limit: MAX_READS=4, buffer holds 6 reads, no responses → deq_c0 high for 4 cycles, fiu_c0_valid 4 pulses each 1 cycle later, rd_outstanding=4, then deq_c0=0. One rsp_c0_read → 5th read issues the next cycle.
- Simultaneous issue and response at limit: rd_cnt=4, rsp_c0_read=1, buf valid → deq_c0=0 that cycle, rd_cnt=3 after the edge, deq_c0=1 the next cycle, rd_cnt returns to 4.
- Almost-full: fiu_c1_alm_full=1 for 3 cycles with a write waiting → deq_c1=0 and fiu_c1_valid=0 for those cycles. First deq_c1 occurs in the cycle alm_full drops; fiu_c1_req equals buf_c1_req from that cycle.
- Drain: 2 reads and 1 write outstanding, drain=1, new requests buffered → no dequeues. Return 2 read responses and 1 write ack → idle=1 the cycle after the last response. drain=0 → deq_c0=1 that same cycle.
- Credit error: rd_cnt=0, rsp_c0_read=1 → credit_err=1 next cycle, rd_cnt stays 0. Issue new traffic → credit_err stays 1 until reset_n=0.
- Reset mid-traffic: rd_cnt=3, fiu_c0_valid=1, reset_n=0 for 1 cycle → all outputs 0 after the edge, deq_c0=0 during reset, normal issue resumes the cycle after reset_n=1.
